// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped, tagged table of 2-bit saturating counters that predicts the
// direction of conditional branches in the FD stage. Each guess is carried
// one stage forward so it can be checked when the branch resolves in X. On
// resolution the table is trained, a mispredict is flagged and the CSR
// performance counters advance.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous, active-low reset (cold table, zero counters)
//   stall          pipeline hold; freezes every register in this block
//   flush          kills the FD instruction; its tracked guess becomes invalid
//   pc_guess       PC of the instruction in FD
//   is_br_guess    FD instruction is a conditional branch
//   br_pred_taken  combinational taken guess for the FD branch
//   pc_check       PC of the instruction in X
//   is_br_check    X instruction is a conditional branch
//   br_taken_check resolved outcome of the X branch
//   mispredict     combinational; X outcome differs from its tracked guess
//   br_count       resolved branches since reset (wraps)
//   mispred_count  mispredicts since reset (wraps)
//
// Stage contract: a guess produced in FD on cycle N (is_br_guess high, not
// stalled) is checked against the X-stage inputs presented on the next
// non-stalled cycle. Table writes land on the clock edge that ends the check
// cycle and are visible to lookups from the following cycle on; a lookup in
// the same cycle as a write to the same index sees the old entry.
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int PC_WIDTH = 32,
    parameter int INDEX_W  = 5,
    parameter int TAG_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] pc_guess,
    input  logic                is_br_guess,
    output logic                br_pred_taken,
    input  logic [PC_WIDTH-1:0] pc_check,
    input  logic                is_br_check,
    input  logic                br_taken_check,
    output logic                mispredict,
    output logic [31:0]         br_count,
    output logic [31:0]         mispred_count
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_LO  = INDEX_W + 2;
    localparam int TAG_HI  = TAG_W + INDEX_W + 1;

    // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_WEAK_T  = 2'b10;
    localparam logic [1:0] CTR_MAX     = 2'b11;
    localparam logic [1:0] CTR_MIN     = 2'b00;

    // Prediction table.
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    // Guess tracked into X.
    logic valid_x;
    logic taken_x;

    // Address decode for both ports.
    logic [INDEX_W-1:0] guess_idx;
    logic [TAG_W-1:0]   guess_tag;
    logic [INDEX_W-1:0] check_idx;
    logic [TAG_W-1:0]   check_tag;

    assign guess_idx = pc_guess[INDEX_W+1:2];
    assign guess_tag = pc_guess[TAG_HI:TAG_LO];
    assign check_idx = pc_check[INDEX_W+1:2];
    assign check_tag = pc_check[TAG_HI:TAG_LO];

    // PC bits outside the index/tag fields do not participate.
    logic unused_pc_bits;
    generate
        if (PC_WIDTH > TAG_HI + 1) begin : g_pc_hi
            assign unused_pc_bits = ^{pc_guess[PC_WIDTH-1:TAG_HI+1], pc_guess[1:0],
                                      pc_check[PC_WIDTH-1:TAG_HI+1], pc_check[1:0]};
        end else begin : g_pc_lo
            assign unused_pc_bits = ^{pc_guess[1:0], pc_check[1:0]};
        end
    endgenerate

    // Lookup (FD side).
    logic guess_hit;
    logic [1:0] guess_ctr;

    always_comb begin
        guess_ctr     = ctr_q[guess_idx];
        guess_hit     = valid_q[guess_idx] && (tag_q[guess_idx] == guess_tag);
        br_pred_taken = is_br_guess && guess_hit && guess_ctr[1];
    end

    // Resolution (X side).
    logic       check_hit;
    logic [1:0] check_ctr;
    logic [1:0] next_ctr;

    always_comb begin
        check_ctr = ctr_q[check_idx];
        check_hit = valid_q[check_idx] && (tag_q[check_idx] == check_tag);
        next_ctr  = check_ctr;
        if (check_hit) begin
            if (br_taken_check) begin
                next_ctr = (check_ctr == CTR_MAX) ? CTR_MAX : check_ctr + 2'd1;
            end else begin
                next_ctr = (check_ctr == CTR_MIN) ? CTR_MIN : check_ctr - 2'd1;
            end
        end else begin
            // Allocation starts at the weak state matching the outcome.
            next_ctr = br_taken_check ? CTR_WEAK_T : CTR_WEAK_NT;
        end
    end

    // An X branch whose guess was flushed or never tracked cannot mispredict.
    assign mispredict = is_br_check && valid_x && (taken_x != br_taken_check);

    // Tracking register, table update and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_x       <= 1'b0;
            taken_x       <= 1'b0;
            br_count      <= 32'd0;
            mispred_count <= 32'd0;
            valid_q       <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= CTR_WEAK_NT;
            end
        end else if (!stall) begin
            // flush wins over is_br_guess: a killed FD branch is not tracked.
            valid_x <= is_br_guess && !flush;
            taken_x <= br_pred_taken;
            if (is_br_check) begin
                // Hit and allocate both end with a valid entry holding this tag.
                valid_q[check_idx] <= 1'b1;
                tag_q[check_idx]   <= check_tag;
                ctr_q[check_idx]   <= next_ctr;
                br_count           <= br_count + 32'd1;
                mispred_count      <= mispred_count + {31'd0, mispredict};
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor. A driver applies one cycle of inputs
// and pushes the hand-computed outputs expected during that cycle; a monitor
// on the falling edge pops and compares.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] pc_guess;
  logic        is_br_guess;
  logic        br_pred_taken;
  logic [31:0] pc_check;
  logic        is_br_check;
  logic        br_taken_check;
  logic        mispredict;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  branch_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .pc_guess       (pc_guess),
    .is_br_guess    (is_br_guess),
    .br_pred_taken  (br_pred_taken),
    .pc_check       (pc_check),
    .is_br_check    (is_br_check),
    .br_taken_check (br_taken_check),
    .mispredict     (mispredict),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  // exp word = {br_pred_taken, mispredict, br_count, mispred_count}
  localparam int W = 66;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  // Running expectation of the statistics counters.
  logic [31:0] m_bc = 32'd0;
  logic [31:0] m_mc = 32'd0;

  task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      compare({nm, ".pred"},    {31'd0, br_pred_taken}, {31'd0, e[65]});
      compare({nm, ".misp"},    {31'd0, mispredict},    {31'd0, e[64]});
      compare({nm, ".brcnt"},   br_count,               e[63:32]);
      compare({nm, ".mispcnt"}, mispred_count,          e[31:0]);
    end
  end

  // ---------------- driver ----------------
  // One cycle: apply inputs, push expected outputs for this cycle, then
  // advance past the next rising edge.
  task automatic step(input string nm,
                      input logic [31:0] pg, input logic bg,
                      input logic [31:0] pcc, input logic bc, input logic tc,
                      input logic st, input logic fl,
                      input logic ep, input logic em);
    pc_guess       = pg;
    is_br_guess    = bg;
    pc_check       = pcc;
    is_br_check    = bc;
    br_taken_check = tc;
    stall          = st;
    flush          = fl;
    if (!rst_n) begin
      m_bc = 32'd0;
      m_mc = 32'd0;
    end
    exp_q.push_back({ep, em, m_bc, m_mc});
    name_q.push_back(nm);
    if (rst_n && bc && !st) begin
      m_bc = m_bc + 32'd1;
      m_mc = m_mc + {31'd0, em};
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] PA = 32'h100;  // idx 0, tag 2
  localparam logic [31:0] PB = 32'h180;  // idx 0, tag 3
  localparam logic [31:0] PC = 32'h200;  // idx 0, tag 4

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; flush = 1'b0;
    pc_guess = '0; is_br_guess = 1'b0;
    pc_check = '0; is_br_check = 1'b0; br_taken_check = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    //    name            pg  bg  pcc bc tc st fl ep em
    step("reset_idle",    0,  0,  0,  0, 0, 0, 0, 0, 0);
    // Cold table
    step("cold_guess",    PA, 1,  0,  0, 0, 0, 0, 0, 0);
    step("cold_check",    0,  0,  PA, 1, 1, 0, 0, 0, 1);
    step("cold_alloc",    PA, 1,  0,  0, 0, 0, 0, 1, 0);
    // Saturation upward (10 -> 11, then held at 11)
    step("sat_t1",        0,  0,  PA, 1, 1, 0, 0, 0, 0);
    step("sat_t2",        0,  0,  PA, 1, 1, 0, 0, 0, 0);
    step("sat_t3",        0,  0,  PA, 1, 1, 0, 0, 0, 0);
    step("sat_t4",        0,  0,  PA, 1, 1, 0, 0, 0, 0);
    step("sat_g11",       PA, 1,  0,  0, 0, 0, 0, 1, 0);
    step("sat_nt1",       0,  0,  PA, 1, 0, 0, 0, 0, 1);
    step("sat_g10",       PA, 1,  0,  0, 0, 0, 0, 1, 0);
    step("sat_nt2",       0,  0,  PA, 1, 0, 0, 0, 0, 1);
    step("sat_g01",       PA, 1,  0,  0, 0, 0, 0, 0, 0);
    step("sat_nt3",       0,  0,  PA, 1, 0, 0, 0, 0, 0);
    step("sat_nt4",       0,  0,  PA, 1, 0, 0, 0, 0, 0);
    step("sat_nt5",       0,  0,  PA, 1, 0, 0, 0, 0, 0);
    step("sat_nt6",       0,  0,  PA, 1, 0, 0, 0, 0, 0);
    // From 00 one taken reaches 01, still not-taken
    step("sat_up1",       0,  0,  PA, 1, 1, 0, 0, 0, 0);
    step("sat_g_floor",   PA, 1,  0,  0, 0, 0, 0, 0, 0);
    // Tag conflict
    step("tag_t1",        0,  0,  PA, 1, 1, 0, 0, 0, 1);
    step("tag_t2",        0,  0,  PA, 1, 1, 0, 0, 0, 0);
    step("tag_g11",       PA, 1,  0,  0, 0, 0, 0, 1, 0);
    step("tag_realloc",   0,  0,  PB, 1, 0, 0, 0, 0, 1);
    step("tag_miss_a",    PA, 1,  0,  0, 0, 0, 0, 0, 0);
    step("tag_g_b01",     PB, 1,  0,  0, 0, 0, 0, 0, 0);
    // Flush
    step("fl_train",      0,  0,  PB, 1, 1, 0, 0, 0, 1);
    step("fl_guess",      PB, 1,  0,  0, 0, 0, 1, 1, 0);
    step("fl_check",      0,  0,  PB, 1, 0, 0, 0, 0, 0);
    // Stall for 3 cycles with check active
    step("st_1",          PB, 1,  PB, 1, 1, 1, 0, 0, 0);
    step("st_2",          PB, 1,  PB, 1, 1, 1, 0, 0, 0);
    step("st_3",          PB, 1,  PB, 1, 1, 1, 0, 0, 0);
    step("st_after",      PB, 1,  0,  0, 0, 0, 0, 0, 0);
    // Same-index race
    step("race_alloc",    0,  0,  PC, 1, 0, 0, 0, 0, 0);
    step("race_same",     PC, 1,  PC, 1, 1, 0, 0, 0, 0);
    step("race_next",     PC, 1,  0,  0, 0, 0, 0, 1, 0);
    // Async reset between edges
    rst_n = 1'b0;
    step("arst_during",   PC, 1,  PC, 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step("arst_cold",     PC, 1,  0,  0, 0, 0, 0, 0, 0);
    step("arst_check",    0,  0,  PC, 1, 1, 0, 0, 0, 1);
    step("arst_counts",   0,  0,  0,  0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped, tagged table of 2-bit saturating counters. It supplies the taken/not-taken guess for a conditional branch in the FD stage; control logic selects the predicted target with pc_sel = 3.
- Carries each guess one stage forward. When the branch resolves in X, it checks the guess, updates the table and flags a mispredict so the PC can be redirected.
- Keeps branch and mispredict counters for CSR performance readout.

Parameters:
- PC_WIDTH, 32, width of PC inputs.
- INDEX_W, 5, table index bits (2^INDEX_W entries); index = pc[INDEX_W+1:2].
- TAG_W, 8, stored tag bits; tag = pc[TAG_W+INDEX_W+1:INDEX_W+2].

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline hold; freezes all state.
- flush  in  1  kills the FD instruction; the tracked guess becomes invalid.
- pc_guess  in  PC_WIDTH  PC of the instruction in FD.
- is_br_guess  in  1  FD instruction is a conditional branch (opcode 0x63).
- br_pred_taken  out  1  combinational guess for the FD branch.
- pc_check  in  PC_WIDTH  PC of the instruction in X.
- is_br_check  in  1  X instruction is a conditional branch.
- br_taken_check  in  1  resolved outcome from X.
- mispredict  out  1  combinational; X branch outcome differs from its tracked guess.
- br_count  out  32  resolved branches since reset.
- mispred_count  out  32  mispredicts since reset.

Behaviour:
- Reset (rst_n low, async):
  - all entries: valid = 0, counter = 2'b01.
  - tracked guess: valid_x = 0, taken_x = 0.
  - both counters = 0.
  - outputs: br_pred_taken = 0, mispredict = 0.
  - Reset mid-operation discards all history; the first cycle after release behaves like a cold table.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Lookup (combinational):
  - hit = valid[idx] && tag[idx] == tag(pc_guess).
  - br_pred_taken = is_br_guess && hit && counter[idx][1].
  - A miss or non-branch gives 0.
- Tracking register (edge, when !stall):
  - valid_x <= is_br_guess && !flush.
  - taken_x <= br_pred_taken.
  - stall holds both registers. flush takes priority over is_br_guess. flush with stall: stall holds.
- mispredict = is_br_check && valid_x && (taken_x != br_taken_check).
  - An X branch with valid_x = 0 never reports a mispredict but still updates the table.
- Update (edge, when is_br_check && !stall), index/tag from pc_check:
  - Tag hit: counter saturating-increments if taken, otherwise decrements. 11 + taken stays 11; 00 + not-taken stays 00.
  - Tag miss or invalid entry: allocate. valid = 1, tag written, counter = 2'b10 if taken else 2'b01.
- Simultaneous lookup and update to the same index: lookup sees the pre-update entry (no bypass). The new value is visible the next cycle.
- Statistics (edge, when is_br_check && !stall):
  - br_count += 1.
  - mispred_count += mispredict.
  - Both wrap modulo 2^32.
- No other state. Latency: guess 0 cycles; table update visible 1 cycle after the check edge.

Test Plan:
- Cold table: reset, pc_guess = 0x100, is_br_guess = 1 -> br_pred_taken = 0. Next cycle, is_br_check = 1, pc_check = 0x100, br_taken_check = 1 -> mispredict = 1, mispred_count = 1, br_count = 1. Entry allocated at 2'b10, so a following guess at 0x100 gives 1.
- Saturation: resolve 0x100 taken 4 times -> counter 11. Resolve not-taken once -> still predicts 1. Resolve not-taken again -> predicts 0. Three more not-taken -> counter 00, and another not-taken leaves it 00.
- Tag conflict: train 0x100 to 11, then resolve 0x100 + (1 << 7) (same index, different tag) not-taken -> entry re-allocated at 01. Guess at 0x100 now returns 0 (miss).
- Flush and stall: is_br_guess = 1 with flush = 1 -> next-cycle X check raises no mispredict, but br_count still increments. Hold stall = 1 for 3 cycles with is_br_check = 1 -> counters and table unchanged.
- Same-index race: guess and check both at 0x200 in the same cycle, entry at 01, resolved taken -> br_pred_taken = 0 that cycle, 1 the following cycle.
- Async reset mid-run: assert rst_n = 0 between clock edges after training -> outputs and counters go to 0 immediately. After release, a guess at a trained PC returns 0.
